// File: rtl/alu_issue.sv
// alu_issue: issue (E) and writeback (W) stages wrapped around an external
// combinational integer ALU for RV32I OP / OP-IMM instructions.
// E holds decoded one-hot controls and operands; W holds the captured result.
// Operands are forwarded from the retiring writeback at capture time (point A)
// and from the W register into the E-stage operand mux (point B).
module alu_issue #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          resetn_i,

  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [2:0]    in_funct3_i,
  input  logic          in_funct7b5_i,
  input  logic          in_is_imm_i,
  input  logic [RW-1:0] in_rs1_addr_i,
  input  logic [RW-1:0] in_rs2_addr_i,
  input  logic [DW-1:0] in_rs1_data_i,
  input  logic [DW-1:0] in_rs2_data_i,
  input  logic [DW-1:0] in_imm_i,
  input  logic [RW-1:0] in_rd_i,

  output logic [1:0]    adder_op_o,
  output logic          sub_en_o,
  output logic [2:0]    shift_op_o,
  output logic [5:0]    compare_op_o,
  output logic          xor_en_o,
  output logic          or_en_o,
  output logic          and_en_o,
  output logic [DW-1:0] data0_o,
  output logic [DW-1:0] data1_o,
  output logic [DW-1:0] compare_data0_o,
  output logic [DW-1:0] compare_data1_o,
  input  logic [DW-1:0] alu_result_i,

  output logic          wb_valid_o,
  input  logic          wb_ready_i,
  output logic [RW-1:0] wb_rd_o,
  output logic [DW-1:0] wb_data_o
);

  localparam int SW = $clog2(DW);

  // E stage state
  logic          e_valid;
  logic [RW-1:0] e_src0;
  logic [RW-1:0] e_src1;   // zero for OP-IMM so the immediate is never forwarded over
  logic [RW-1:0] e_rd;
  logic [DW-1:0] e_op0;
  logic [DW-1:0] e_op1;
  logic          e_add;
  logic          e_sub;
  logic [2:0]    e_shift;
  logic [5:0]    e_cmp;
  logic          e_xor;
  logic          e_or;
  logic          e_and;

  // W stage state
  logic          w_valid;
  logic [RW-1:0] w_rd;
  logic [DW-1:0] w_data;

  // handshake / flow
  logic w_free;
  logic e_adv;
  logic in_fire;
  logic wb_fire;

  // decode of the incoming instruction
  logic          dec_add;
  logic          dec_sub;
  logic [2:0]    dec_shift;
  logic [5:0]    dec_cmp;
  logic          dec_xor;
  logic          dec_or;
  logic          dec_and;

  // capture-side operands (after point A)
  logic          fwd_a0;
  logic          fwd_a1;
  logic [DW-1:0] cap_op0;
  logic [DW-1:0] cap_op1;

  // E-side operands (after point B)
  logic          fwd_b0;
  logic          fwd_b1;
  logic [DW-1:0] op0_fwd;
  logic [DW-1:0] op1_fwd;

  // Pipeline flow: E may move whenever W is empty or draining this cycle.
  always_comb begin
    w_free     = !w_valid || wb_ready_i;
    e_adv      = e_valid && w_free;
    in_ready_o = !e_valid || e_adv;
    in_fire    = in_valid_i && in_ready_o;
    wb_fire    = w_valid && wb_ready_i;
  end

  // funct3/funct7 decode into one-hot ALU control enables.
  always_comb begin
    dec_add   = 1'b0;
    dec_sub   = 1'b0;
    dec_shift = 3'b000;
    dec_cmp   = 6'b000000;
    dec_xor   = 1'b0;
    dec_or    = 1'b0;
    dec_and   = 1'b0;
    case (in_funct3_i)
      3'b000: begin
        // only register-register ADD/SUB honour instr[30]; ADDI always adds
        if (!in_is_imm_i && in_funct7b5_i) dec_sub = 1'b1;
        else                               dec_add = 1'b1;
      end
      3'b001:  dec_shift = 3'b001;
      3'b010:  dec_cmp   = 6'b000100;
      3'b011:  dec_cmp   = 6'b010000;
      3'b100:  dec_xor   = 1'b1;
      3'b101:  dec_shift = in_funct7b5_i ? 3'b100 : 3'b010;
      3'b110:  dec_or    = 1'b1;
      3'b111:  dec_and   = 1'b1;
      default: ;
    endcase
  end

  // Point A: a value retiring this very cycle has not reached the regfile read yet.
  always_comb begin
    fwd_a0  = wb_fire && (w_rd == in_rs1_addr_i) && (in_rs1_addr_i != '0);
    fwd_a1  = wb_fire && (w_rd == in_rs2_addr_i) && (in_rs2_addr_i != '0) && !in_is_imm_i;
    cap_op0 = fwd_a0 ? w_data : in_rs1_data_i;
    if (in_is_imm_i) cap_op1 = in_imm_i;
    else             cap_op1 = fwd_a1 ? w_data : in_rs2_data_i;
  end

  // E register: load on accept, empty out (controls cleared) when it advances alone.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      e_valid <= 1'b0;
      e_src0  <= '0;
      e_src1  <= '0;
      e_rd    <= '0;
      e_op0   <= '0;
      e_op1   <= '0;
      e_add   <= 1'b0;
      e_sub   <= 1'b0;
      e_shift <= 3'b000;
      e_cmp   <= 6'b000000;
      e_xor   <= 1'b0;
      e_or    <= 1'b0;
      e_and   <= 1'b0;
    end else if (in_fire) begin
      e_valid <= 1'b1;
      e_src0  <= in_rs1_addr_i;
      e_src1  <= in_is_imm_i ? '0 : in_rs2_addr_i;
      e_rd    <= in_rd_i;
      e_op0   <= cap_op0;
      e_op1   <= cap_op1;
      e_add   <= dec_add;
      e_sub   <= dec_sub;
      e_shift <= dec_shift;
      e_cmp   <= dec_cmp;
      e_xor   <= dec_xor;
      e_or    <= dec_or;
      e_and   <= dec_and;
    end else if (e_adv) begin
      e_valid <= 1'b0;
      e_add   <= 1'b0;
      e_sub   <= 1'b0;
      e_shift <= 3'b000;
      e_cmp   <= 6'b000000;
      e_xor   <= 1'b0;
      e_or    <= 1'b0;
      e_and   <= 1'b0;
    end
  end

  // Point B: the W result is newer than anything captured into E.
  always_comb begin
    fwd_b0  = w_valid && (w_rd == e_src0) && (e_src0 != '0);
    fwd_b1  = w_valid && (w_rd == e_src1) && (e_src1 != '0);
    op0_fwd = fwd_b0 ? w_data : e_op0;
    op1_fwd = fwd_b1 ? w_data : e_op1;
  end

  // ALU operand drive; shift amount is masked after forwarding.
  always_comb begin
    data0_o = op0_fwd;
    data1_o = op1_fwd;
    if (|e_shift) data1_o[DW-1:SW] = '0;
    compare_data0_o = data0_o;
    compare_data1_o = data1_o;
  end

  // Control outputs straight from the E register (already zero when E is empty).
  always_comb begin
    adder_op_o   = {1'b0, e_add};
    sub_en_o     = e_sub;
    shift_op_o   = e_shift;
    compare_op_o = e_cmp;
    xor_en_o     = e_xor;
    or_en_o      = e_or;
    and_en_o     = e_and;
  end

  // W register: capture the ALU result as E advances; rd=0 always writes back zero.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      w_valid <= 1'b0;
      w_rd    <= '0;
      w_data  <= '0;
    end else if (e_adv) begin
      w_valid <= 1'b1;
      w_rd    <= e_rd;
      w_data  <= (e_rd == '0) ? '0 : alu_result_i;
    end else if (wb_ready_i) begin
      w_valid <= 1'b0;
    end
  end

  // Writeback interface
  always_comb begin
    wb_valid_o = w_valid;
    wb_rd_o    = w_rd;
    wb_data_o  = w_data;
  end

endmodule
